// File: rtl/dmem_responder.sv
// Word-addressed data RAM serving lw/sw with LATENCY stall cycles per access.
// mem_stall holds the pipeline until the commit cycle; load data lands registered one cycle later.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    parameter int AW      = 8
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        mem_stall_o,
    output logic [1:0]  err_o
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [3:0] CNT_INIT = 4'((LATENCY > 0) ? (LATENCY - 1) : 0);

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic          op_wr_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          rvld_q;
    logic [1:0]    err_q;
    logic [31:0]   ram_q [DEPTH];

    logic          req;
    logic          misal;
    logic          ok;
    logic [AW-1:0] idx_in;
    logic          commit;
    logic          c_wr;
    logic [AW-1:0] c_idx;
    logic [31:0]   c_wd;
    logic          stall;
    logic          unused_addr;

    assign req         = mem_read_i | mem_write_i;
    assign misal       = req && (addr_i[1:0] != 2'b00);
    assign ok          = req && !misal;
    assign idx_in      = addr_i[AW+1:2];
    assign unused_addr = ^addr_i[31:AW+2];

    // In WAIT everything comes from the latched copy, so input wiggles are ignored.
    always_comb begin
        commit = 1'b0;
        stall  = 1'b0;
        c_wr   = mem_write_i;
        c_idx  = idx_in;
        c_wd   = wdata_i;
        if (state_q == S_IDLE) begin
            commit = ok && (LATENCY == 0);
            stall  = ok && (LATENCY != 0);
        end else begin
            commit = (cnt_q == 4'd0);
            stall  = (cnt_q != 4'd0);
            c_wr   = op_wr_q;
            c_idx  = idx_q;
            c_wd   = wdata_q;
        end
    end

    // RAM contents survive reset; a write pending when reset hits is dropped.
    always_ff @(posedge clk_i) begin
        if (commit && c_wr && rst_n_i) begin
            ram_q[c_idx] <= c_wd;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rvld_q  <= 1'b0;
            err_q   <= 2'b00;
        end else begin
            rvld_q <= commit && !c_wr;
            if (commit && !c_wr) begin
                rdata_q <= ram_q[c_idx];
            end
            case (state_q)
                S_IDLE: begin
                    if (misal) begin
                        err_q[0] <= 1'b1;
                    end
                    // Read+write together is serviced as a store.
                    if (mem_read_i && mem_write_i) begin
                        err_q[1] <= 1'b1;
                    end
                    if (ok && (LATENCY != 0)) begin
                        state_q <= S_WAIT;
                        cnt_q   <= CNT_INIT;
                        op_wr_q <= mem_write_i;
                        idx_q   <= idx_in;
                        wdata_q <= wdata_i;
                    end
                end
                S_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rvld_q;
    assign mem_stall_o   = stall;
    assign err_o         = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 0, 3) against a transaction-level memory model.
module tb_dmem_responder;

    logic        clk;
    logic        rst_n       [3];
    logic        mem_read    [3];
    logic        mem_write   [3];
    logic [31:0] addr        [3];
    logic [31:0] wdata       [3];
    logic [31:0] rdata       [3];
    logic        rdata_valid [3];
    logic        mem_stall   [3];
    logic [1:0]  err         [3];

    int lat [3] = '{2, 0, 3};

    dmem_responder #(.DEPTH(256), .LATENCY(2), .AW(8)) u_l2 (
        .clk_i(clk), .rst_n_i(rst_n[0]), .mem_read_i(mem_read[0]), .mem_write_i(mem_write[0]),
        .addr_i(addr[0]), .wdata_i(wdata[0]), .rdata_o(rdata[0]), .rdata_valid_o(rdata_valid[0]),
        .mem_stall_o(mem_stall[0]), .err_o(err[0]));
    dmem_responder #(.DEPTH(256), .LATENCY(0), .AW(8)) u_l0 (
        .clk_i(clk), .rst_n_i(rst_n[1]), .mem_read_i(mem_read[1]), .mem_write_i(mem_write[1]),
        .addr_i(addr[1]), .wdata_i(wdata[1]), .rdata_o(rdata[1]), .rdata_valid_o(rdata_valid[1]),
        .mem_stall_o(mem_stall[1]), .err_o(err[1]));
    dmem_responder #(.DEPTH(256), .LATENCY(3), .AW(8)) u_l3 (
        .clk_i(clk), .rst_n_i(rst_n[2]), .mem_read_i(mem_read[2]), .mem_write_i(mem_write[2]),
        .addr_i(addr[2]), .wdata_i(wdata[2]), .rdata_o(rdata[2]), .rdata_valid_o(rdata_valid[2]),
        .mem_stall_o(mem_stall[2]), .err_o(err[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per-instance word array, last load value, pending valid pulse, sticky errors.
    logic [31:0] mm      [3][256];
    logic [31:0] last_rd [3];
    bit          pend_v  [3];
    logic [1:0]  err_m   [3];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic sample(input int k);
        chk($sformatf("valid[%0d]", k), 32'(rdata_valid[k]), 32'(pend_v[k]));
        chk($sformatf("rdata[%0d]", k), rdata[k], last_rd[k]);
        chk($sformatf("err[%0d]", k), 32'(err[k]), 32'(err_m[k]));
        pend_v[k] = 1'b0;
    endtask

    task automatic drive_idle(input int k);
        mem_read[k]  = 1'b0;
        mem_write[k] = 1'b0;
        addr[k]      = 32'h0;
        wdata[k]     = 32'h0;
    endtask

    task automatic idle(input int k);
        @(negedge clk);
        sample(k);
        chk($sformatf("idle_stall[%0d]", k), 32'(mem_stall[k]), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Entered just after a rising edge; leaves just after the edge following the commit cycle.
    task automatic access(input int k, input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input bit chg, input logic [31:0] a2,
                          output int stalls);
        bit       al;
        bit       done;
        int       idx;
        al  = (a[1:0] == 2'b00);
        idx = int'(a[9:2]);
        mem_read[k]  = rd;
        mem_write[k] = wr;
        addr[k]      = a;
        wdata[k]     = wd;
        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            sample(k);
            if (c == 0) begin
                if (!al)      err_m[k][0] = 1'b1;
                if (rd && wr) err_m[k][1] = 1'b1;
            end
            if (!mem_stall[k]) begin
                done = 1'b1;
            end else begin
                stalls++;
                @(posedge clk);
                #1;
                if (chg) addr[k] = a2;
            end
        end
        if (!done) chk($sformatf("stall_timeout[%0d]", k), 32'd1, 32'd0);
        if (al) begin
            if (wr) begin
                mm[k][idx] = wd;
            end else begin
                last_rd[k] = mm[k][idx];
                pend_v[k]  = 1'b1;
            end
        end
        chk($sformatf("stall_cycles[%0d]", k), 32'(stalls), al ? 32'(lat[k]) : 32'd0);
        @(posedge clk);
        #1;
        drive_idle(k);
    endtask

    typedef struct {
        int          k;
        bit          rd;
        bit          wr;
        logic [31:0] a;
        logic [31:0] wd;
        bit          chg;
        logic [31:0] a2;
        int          st;
        bit          v;
        logic [31:0] rdx;
        logic [1:0]  e;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          st;
        logic [31:0] a;
        bit          rd;
        bit          wr;

        // k, rd, wr, addr, wdata, chg, addr-during-wait, stalls, valid, rdata after, err after
        tbl[0]  = '{0, 1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0, 2, 1'b0, 32'h0,        2'b00};
        tbl[1]  = '{0, 1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 32'h0, 2, 1'b1, 32'hDEADBEEF, 2'b00};
        tbl[2]  = '{0, 1'b0, 1'b1, 32'h400, 32'h5A,       1'b0, 32'h0, 2, 1'b0, 32'hDEADBEEF, 2'b00};
        tbl[3]  = '{0, 1'b1, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0, 2, 1'b1, 32'h5A,       2'b00};
        tbl[4]  = '{0, 1'b1, 1'b0, 32'h2,   32'h0,        1'b0, 32'h0, 0, 1'b0, 32'h5A,       2'b01};
        tbl[5]  = '{0, 1'b0, 1'b1, 32'h20,  32'h99,       1'b0, 32'h0, 2, 1'b0, 32'h5A,       2'b01};
        tbl[6]  = '{1, 1'b1, 1'b1, 32'h30,  32'h1,        1'b0, 32'h0, 0, 1'b0, 32'h0,        2'b10};
        tbl[7]  = '{1, 1'b1, 1'b0, 32'h30,  32'h0,        1'b0, 32'h0, 0, 1'b1, 32'h1,        2'b10};
        tbl[8]  = '{2, 1'b0, 1'b1, 32'h8,   32'hAAAA0008, 1'b0, 32'h0, 3, 1'b0, 32'h0,        2'b00};
        tbl[9]  = '{2, 1'b0, 1'b1, 32'hC,   32'hBBBB000C, 1'b0, 32'h0, 3, 1'b0, 32'h0,        2'b00};
        tbl[10] = '{2, 1'b1, 1'b0, 32'h8,   32'h0,        1'b1, 32'hC, 3, 1'b1, 32'hAAAA0008, 2'b00};

        for (int k = 0; k < 3; k++) begin
            rst_n[k]   = 1'b0;
            drive_idle(k);
            last_rd[k] = 32'h0;
            pend_v[k]  = 1'b0;
            err_m[k]   = 2'b00;
        end

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_rdata[%0d]", k), rdata[k], 32'h0);
            chk($sformatf("rst_valid[%0d]", k), 32'(rdata_valid[k]), 32'd0);
            chk($sformatf("rst_stall[%0d]", k), 32'(mem_stall[k]), 32'd0);
            chk($sformatf("rst_err[%0d]", k), 32'(err[k]), 32'd0);
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
        @(posedge clk);
        #1;

        // Directed table
        for (int i = 0; i < 11; i++) begin
            access(tbl[i].k, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].chg, tbl[i].a2, st);
            chk($sformatf("tbl%0d_stalls", i), 32'(st), 32'(tbl[i].st));
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", i), 32'(rdata_valid[tbl[i].k]), 32'(tbl[i].v));
            chk($sformatf("tbl%0d_rdata", i), rdata[tbl[i].k], tbl[i].rdx);
            chk($sformatf("tbl%0d_err", i), 32'(err[tbl[i].k]), 32'(tbl[i].e));
            sample(tbl[i].k);
            @(posedge clk);
            #1;
        end

        // Reset during the second WAIT cycle of a store aborts it
        mem_write[0] = 1'b1;
        addr[0]      = 32'h20;
        wdata[0]     = 32'h77;
        @(negedge clk);
        sample(0);
        chk("abort_stall_c0", 32'(mem_stall[0]), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        sample(0);
        chk("abort_stall_c1", 32'(mem_stall[0]), 32'd1);
        @(posedge clk);
        #1;
        rst_n[0] = 1'b0;
        drive_idle(0);
        #2;
        chk("abort_rdata", rdata[0], 32'h0);
        chk("abort_valid", 32'(rdata_valid[0]), 32'd0);
        chk("abort_stall", 32'(mem_stall[0]), 32'd0);
        chk("abort_err", 32'(err[0]), 32'd0);
        last_rd[0] = 32'h0;
        pend_v[0]  = 1'b0;
        err_m[0]   = 2'b00;
        @(negedge clk);
        rst_n[0] = 1'b1;
        sample(0);
        @(posedge clk);
        #1;
        access(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0, st);
        @(negedge clk);
        chk("abort_reload_valid", 32'(rdata_valid[0]), 32'd1);
        chk("abort_reload_rdata", rdata[0], 32'h99);
        sample(0);
        @(posedge clk);
        #1;

        // Zero-latency store then load on consecutive cycles
        access(1, 1'b0, 1'b1, 32'h4, 32'h11, 1'b0, 32'h0, st);
        access(1, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 32'h0, st);
        @(negedge clk);
        chk("b2b_valid", 32'(rdata_valid[1]), 32'd1);
        chk("b2b_rdata", rdata[1], 32'h11);
        sample(1);
        @(posedge clk);
        #1;

        // Randomized traffic over a 16-word window, with aliased upper address bits
        for (int k = 0; k < 3; k++) begin
            for (int w = 16; w < 32; w++) begin
                access(k, 1'b0, 1'b1, 32'(w) << 2, $urandom, 1'b0, 32'h0, st);
            end
            for (int n = 0; n < 150; n++) begin
                int r;
                r = $urandom_range(0, 19);
                a = ($urandom & 32'hFFFF_FC00) | (32'(16 + $urandom_range(0, 15)) << 2);
                rd = ($urandom_range(0, 1) == 1);
                wr = !rd;
                if (r == 0) a = a | 32'($urandom_range(1, 3));
                if (r == 1) begin
                    rd = 1'b1;
                    wr = 1'b1;
                end
                access(k, rd, wr, a, $urandom, ($urandom_range(0, 1) == 1), $urandom, st);
                if ($urandom_range(0, 3) == 0) idle(k);
            end
            idle(k);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the 5-stage RISC-V pipeline; the memory-side end of the mem_read/mem_write request issued by the main control decoder and carried through EX/MEM.
- Holds a word-addressed data RAM and performs lw/sw accesses with a configurable wait latency.
- Raises mem_stall so the pipeline freezes until the access completes; delivers load data registered, aligned with the MEM/WB transfer.

Parameters:
- DEPTH, 256, number of 32-bit words; power of 2.
- LATENCY, 2, stall cycles per access; 0..15.
- AW, 8, word-index width = log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- mem_read  input  1  load request from EX/MEM.
- mem_write  input  1  store request from EX/MEM.
- addr  input  32  byte address (ALU result).
- wdata  input  32  store data.
- rdata  output  32  registered load data.
- rdata_valid  output  1  one-cycle pulse: rdata updated by a completed load.
- mem_stall  output  1  combinational; freeze PC, IF/ID, ID/EX, EX/MEM.
- err  output  2  sticky: [0] misaligned access, [1] read+write asserted together.

Behaviour:
- Reset (async, rst_n low): state=IDLE, cnt=0, rdata=0, rdata_valid=0, err=0, mem_stall=0. Latched request cleared; any pending access aborted and a pending write is not committed. The RAM array is not reset; its contents persist across reset and are undefined at power-up.
- req = mem_read | mem_write. Word index = addr[AW+1:2]; upper bits ignored, so the index wraps modulo DEPTH.
- States: IDLE, WAIT.
- IDLE, no req:
  - mem_stall=0; nothing happens.
- IDLE, req, LATENCY=0:
  - no stall.
  - Access commits at the end of this cycle.
  - Load: rdata is loaded and rdata_valid=1 in the next cycle.
- IDLE, req, LATENCY=N>0:
  - mem_stall=1.
  - Latch op/index/wdata.
  - cnt<=N-1; go to WAIT.
- WAIT, cnt!=0:
  - mem_stall=1; cnt decrements.
- WAIT, cnt=0:
  - mem_stall=0.
  - Access commits at the end of this cycle using the latched values; return to IDLE.
  - Load: rdata_valid=1 in the next cycle.
- Net timing: request first seen in cycle T -> mem_stall high for exactly N cycles (T..T+N-1) -> commit at end of T+N -> rdata_valid pulse in cycle T+N+1.
- The pipeline holds the request stable while mem_stall=1; the responder uses only its latched copy, so changes to the inputs during WAIT are ignored.
- Store: RAM[index]<=wdata at commit. rdata and rdata_valid are unchanged.
- rdata holds its last load value between loads. rdata_valid is high for exactly 1 cycle per load, never for stores.
- Back-to-back requests: a new request may be accepted in the cycle immediately after a commit (no bubble).
- A load that follows a store to the same word returns the stored data, because the store commits first.
- Misaligned (addr[1:0]!=0 with req):
  - No RAM access, no stall, no rdata_valid.
  - err[0] set; stays set until reset.
- mem_read & mem_write both asserted:
  - Treated as a store; err[1] set, sticky.
- mem_stall has a combinational path from mem_read/mem_write/addr in IDLE only; in WAIT it is a function of registered state only.

Test Plan:
- LATENCY=2, sw addr=0x10 wdata=0xDEADBEEF, then lw addr=0x10 -> stall high 2 cycles per access; rdata=0xDEADBEEF with rdata_valid pulse in cycle T+3 of the load.
- LATENCY=0, sw 0x4=0x11, lw 0x4 on consecutive cycles -> mem_stall never high; rdata=0x11 with valid in the cycle after the lw.
- LATENCY=3, lw addr=0x8 held; addr changed to 0xC during WAIT -> the data returned is RAM[2], not RAM[3]; stall high exactly 3 cycles.
- DEPTH=256, sw addr=0x400 wdata=0x5A -> lw addr=0x0 returns 0x5A (wrap); misaligned lw addr=0x2 -> err=2'b01, no stall, no valid.
- rst_n pulsed low in the 2nd WAIT cycle of sw addr=0x20 wdata=0x77 (RAM[8]=0x99 beforehand) -> outputs zero immediately; later lw 0x20 returns 0x99.
- mem_read=mem_write=1 at addr 0x30 wdata=0x1 -> err[1]=1, RAM[12]=0x1, no rdata_valid.
